// File: rtl/m_mem_access_ctrl.sv
// Memory-stage load/store controller: decodes MIPS memory ops, runs a req/ack
// bus transaction, stalls the pipeline while it is outstanding, and extends load data.
module m_mem_access_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        M_valid,
    input  logic [31:0] M_inStr,
    input  logic [31:0] M_aluResult,
    input  logic [31:0] M_ALU_src2_temp,
    output logic        M_stall,
    output logic        M_excAd,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] M_loadData,
    output logic        M_loadValid
);

    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = 4;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [DW-1:0]    addr_q, addr_d;
    logic [BEW-1:0]   be_q, be_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    ldata_q, ldata_d;
    logic             lvalid_q, lvalid_d;
    size_t            size_q, size_d;
    logic             sgn_q, sgn_d;
    logic [1:0]       lane_q, lane_d;

    logic [5:0]       opcode;
    logic             is_mem, is_load, is_sgn, misalign, mem_op;
    size_t            size_c;
    logic [BEW-1:0]   be_c;
    logic [DW-1:0]    wdata_c, ext_c;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic             unused_instr;

    assign opcode       = M_inStr[31:26];
    assign unused_instr = ^M_inStr[25:0];

    // Opcode decode: access size, direction and signedness
    always_comb begin
        is_mem  = 1'b1;
        is_load = 1'b0;
        is_sgn  = 1'b0;
        size_c  = SZ_W;
        case (opcode)
            6'h23: is_load = 1'b1;
            6'h20: begin is_load = 1'b1; is_sgn = 1'b1; size_c = SZ_B; end
            6'h24: begin is_load = 1'b1; size_c = SZ_B; end
            6'h21: begin is_load = 1'b1; is_sgn = 1'b1; size_c = SZ_H; end
            6'h25: begin is_load = 1'b1; size_c = SZ_H; end
            6'h2B: size_c = SZ_W;
            6'h28: size_c = SZ_B;
            6'h29: size_c = SZ_H;
            default: is_mem = 1'b0;
        endcase
    end

    always_comb begin
        case (size_c)
            SZ_W:    misalign = |M_aluResult[1:0];
            SZ_H:    misalign = M_aluResult[0];
            default: misalign = 1'b0;
        endcase
    end

    assign M_excAd = M_valid & is_mem & misalign;
    assign mem_op  = M_valid & is_mem & ~misalign;
    assign M_stall = mem_op & (state_q != S_DONE);

    // Byte enables and lane-replicated store data from the current request
    always_comb begin
        case (size_c)
            SZ_W: begin
                be_c    = 4'b1111;
                wdata_c = M_ALU_src2_temp;
            end
            SZ_H: begin
                be_c    = M_aluResult[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{M_ALU_src2_temp[15:0]}};
            end
            default: begin
                be_c    = BEW'(4'b0001 << M_aluResult[1:0]);
                wdata_c = {4{M_ALU_src2_temp[7:0]}};
            end
        endcase
        if (is_load) wdata_c = '0;
    end

    assign byte_v = 8'(bus_rdata >> {lane_q, 3'b000});
    assign half_v = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        case (size_q)
            SZ_B:    ext_c = {{24{sgn_q & byte_v[7]}}, byte_v};
            SZ_H:    ext_c = {{16{sgn_q & half_v[15]}}, half_v};
            default: ext_c = bus_rdata;
        endcase
    end

    // Next-state and registered bus/load outputs
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        ldata_d  = ldata_q;
        lvalid_d = lvalid_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        lane_d   = lane_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    req_d   = 1'b1;
                    we_d    = ~is_load;
                    addr_d  = {M_aluResult[31:2], 2'b00};
                    be_d    = be_c;
                    wdata_d = wdata_c;
                    size_d  = size_c;
                    sgn_d   = is_sgn;
                    lane_d  = M_aluResult[1:0];
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        ldata_d  = ext_c;
                        lvalid_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                lvalid_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            ldata_q  <= '0;
            lvalid_q <= 1'b0;
            size_q   <= SZ_B;
            sgn_q    <= 1'b0;
            lane_q   <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            ldata_q  <= ldata_d;
            lvalid_q <= lvalid_d;
            size_q   <= size_d;
            sgn_q    <= sgn_d;
            lane_q   <= lane_d;
        end
    end

    assign bus_req     = req_q;
    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_be      = be_q;
    assign bus_wdata   = wdata_q;
    assign M_loadData  = ldata_q;
    assign M_loadValid = lvalid_q;

endmodule

// File: tb/tb_m_mem_access_ctrl.sv
// Bench for m_mem_access_ctrl: directed cases plus random ops checked against
// an arithmetic model of access size, lanes, extension and stall length.
module tb_m_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        M_valid;
    logic [31:0] M_inStr, M_aluResult, M_ALU_src2_temp;
    logic        M_stall, M_excAd, bus_req, bus_we, bus_ack, M_loadValid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata, M_loadData;
    logic [3:0]  bus_be;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_ld = '0;

    m_mem_access_ctrl dut (
        .clk(clk), .reset(reset), .M_valid(M_valid), .M_inStr(M_inStr),
        .M_aluResult(M_aluResult), .M_ALU_src2_temp(M_ALU_src2_temp),
        .M_stall(M_stall), .M_excAd(M_excAd), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .M_loadData(M_loadData), .M_loadValid(M_loadValid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: access size in bytes (0 = not a memory op)
    function automatic int op_bytes(input logic [5:0] op);
        case (op)
            6'h23, 6'h2B:        return 4;
            6'h21, 6'h25, 6'h29: return 2;
            6'h20, 6'h24, 6'h28: return 1;
            default:             return 0;
        endcase
    endfunction

    function automatic bit op_load(input logic [5:0] op);
        return (op == 6'h23) || (op == 6'h20) || (op == 6'h24) || (op == 6'h21) || (op == 6'h25);
    endfunction

    function automatic bit op_signed(input logic [5:0] op);
        return (op == 6'h20) || (op == 6'h21);
    endfunction

    function automatic logic [31:0] model_wdata(input int n, input logic [31:0] rt);
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = rt[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input int n, input bit sgn,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        logic [63:0] v = 64'(rdata >> (8 * addr[1:0]));
        logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
        v = v & mask;
        if (sgn && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic run_op(input bit v, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] rdata, input int wt);
        int n = op_bytes(op);
        bit memop = v && (n != 0) && (addr % n == 0);
        bit exc   = v && (n != 0) && (addr % n != 0);
        bit ld    = op_load(op);
        int stalls = 0, reqs = 0;
        bit seen = 0, done = 0, first = 1;
        logic [31:0] exp_ld;
        @(posedge clk); #1;
        M_valid = v;
        M_inStr = {op, 26'($urandom)};
        M_aluResult = addr;
        M_ALU_src2_temp = rt;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (first) begin
                check_eq("excAd", 32'(M_excAd), 32'(exc));
                check_eq("req_idle", 32'(bus_req), 0);
                check_eq("lvalid_idle", 32'(M_loadValid), 0);
                check_eq("ldata_hold", M_loadData, last_ld);
                first = 0;
            end
            if (bus_req && !seen) begin
                check_eq("we", 32'(bus_we), 32'(!ld));
                check_eq("addr", bus_addr, {addr[31:2], 2'b00});
                check_eq("be", 32'(bus_be), 32'(((1 << n) - 1) << addr[1:0]));
                check_eq("wdata", bus_wdata, ld ? 32'h0 : model_wdata(n, rt));
                seen = 1;
            end
            if (bus_req) begin
                if (reqs == wt) begin
                    bus_ack = 1'b1;
                    bus_rdata = rdata;
                end
                reqs++;
            end
            if (M_stall) stalls++;
            else begin
                done = 1;
                break;
            end
        end
        check_eq("stall_cycles", 32'(stalls), memop ? 32'(2 + wt) : 32'h0);
        if (!done) check_eq("timeout", 0, 1);
        if (memop) begin
            check_eq("req_seen", 32'(seen), 1);
            check_eq("lvalid_done", 32'(M_loadValid), 32'(ld));
            if (ld) begin
                exp_ld = model_load(n, op_signed(op), addr, rdata);
                check_eq("load_data", M_loadData, exp_ld);
                last_ld = exp_ld;
            end
        end else begin
            bus_ack = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        logic [5:0] ops [11] = '{6'h23, 6'h20, 6'h24, 6'h21, 6'h25, 6'h2B, 6'h28, 6'h29,
                                 6'h00, 6'h0F, 6'h22};
        reset = 1'b1; M_valid = 0; M_inStr = 0; M_aluResult = 0; M_ALU_src2_temp = 0;
        bus_ack = 0; bus_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", 32'(bus_req), 0);
        check_eq("rst_we", 32'(bus_we), 0);
        check_eq("rst_addr", bus_addr, 0);
        check_eq("rst_be", 32'(bus_be), 0);
        check_eq("rst_wdata", bus_wdata, 0);
        check_eq("rst_ldata", M_loadData, 0);
        check_eq("rst_lvalid", 32'(M_loadValid), 0);
        reset = 1'b0;

        // Directed cases
        run_op(1, 6'h2B, 32'h100, 32'hDEADBEEF, 0, 0);
        run_op(1, 6'h28, 32'h103, 32'h000000A5, 0, 0);
        run_op(1, 6'h29, 32'h102, 32'h00001234, 0, 1);
        run_op(1, 6'h20, 32'h101, 0, 32'h00008000, 3);
        run_op(1, 6'h24, 32'h101, 0, 32'h00008000, 0);
        run_op(1, 6'h21, 32'h102, 0, 32'h8001FFFF, 0);
        run_op(1, 6'h23, 32'h101, 0, 32'h12345678, 0);
        run_op(1, 6'h25, 32'h103, 0, 32'h12345678, 0);
        run_op(1, 6'h23, 32'h104, 0, 32'hCAFEF00D, 0);
        run_op(1, 6'h25, 32'h106, 0, 32'h9ABC0000, 2);
        run_op(0, 6'h23, 32'h108, 0, 32'h11111111, 0);

        // Reset during the second REQ cycle of a lw, then a late ack
        @(posedge clk); #1;
        M_valid = 1; M_inStr = {6'h23, 26'h0}; M_aluResult = 32'h200;
        @(negedge clk);
        @(negedge clk);
        check_eq("rq_req1", 32'(bus_req), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("rq_req2", 32'(bus_req), 1);
        @(posedge clk); #1;
        reset = 1'b0; M_valid = 0; bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
        last_ld = '0;
        @(negedge clk);
        check_eq("rq_req_drop", 32'(bus_req), 0);
        check_eq("rq_lvalid", 32'(M_loadValid), 0);
        check_eq("rq_stall", 32'(M_stall), 0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check_eq("late_ack_req", 32'(bus_req), 0);
        check_eq("late_ack_lvalid", 32'(M_loadValid), 0);
        check_eq("late_ack_ldata", M_loadData, 0);
        run_op(1, 6'h23, 32'h200, 0, 32'h87654321, 1);

        // Random ops
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a = $urandom;
            run_op($urandom_range(0, 9) != 0, ops[$urandom_range(0, 10)],
                   $urandom_range(0, 2) == 0 ? a : {a[31:2], 2'b00},
                   $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_mem_access_ctrl.md
# m_mem_access_ctrl

Memory-stage access controller that consumes the E→M pipeline register outputs. It decodes MIPS load/store instructions and drives a req/ack data bus with byte enables and replicated store data. While the bus transaction is outstanding it stalls the pipeline, and it returns sign- or zero-extended load data to the M→W path. It sits between the M pipeline register and the external data memory, and its stall output gates that register's update.

## Interface
- No parameters; data and address width fixed at 32, byte-addressed, little-endian.
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- M_valid  in  1  M-stage slot holds a real instruction (0 = bubble)
- M_inStr  in  32  M-stage instruction word; opcode = [31:26]
- M_aluResult  in  32  effective byte address
- M_ALU_src2_temp  in  32  forwarded rt value (store data)
- M_stall  out  1  combinational; hold E→M register, insert bubble into M→W
- M_excAd  out  1  combinational; misaligned access, no bus activity
- bus_req  out  1  registered; request pending
- bus_we  out  1  registered; 1 = store
- bus_addr  out  32  registered; {M_aluResult[31:2], 2'b00}
- bus_be  out  4  registered byte enables
- bus_wdata  out  32  registered replicated store data
- bus_ack  in  1  one-cycle completion pulse from memory
- bus_rdata  in  32  read word, valid when bus_ack=1
- M_loadData  out  32  registered extended load result
- M_loadValid  out  1  registered; 1 for exactly one cycle per completed load

## Operation
- Memory ops: lw 0x23, lb 0x20, lbu 0x24, lh 0x21, lhu 0x25, sw 0x2B, sb 0x28, sh 0x29. All other opcodes, and any op with M_valid=0, are non-memory.
- mem_op = M_valid & opcode in memory set & !M_excAd.
- M_excAd: lw/sw with addr[1:0]!=0; lh/lhu/sh with addr[0]!=0. Byte ops are never misaligned.
- States: IDLE, REQ, DONE.
- IDLE: if mem_op, load bus_addr/be/we/wdata, set bus_req=1, go REQ; else stay.
- REQ: bus_req held high, bus fields stable. On bus_ack: bus_req←0. For loads, M_loadData←extended bus_rdata and M_loadValid←1. Go DONE.
- DONE: M_loadValid cleared at next edge; go IDLE unconditionally.
- M_stall = mem_op & (state != DONE). Upstream holds all M inputs stable while M_stall=1.
- Byte enables:
  - word: 1111
  - half: addr[1] ? 1100 : 0011
  - byte: 0001 << addr[1:0]
  - Loads drive the same be pattern as stores.
- Store data:
  - sw: rt
  - sh: {2{rt[15:0]}}
  - sb: {4{rt[7:0]}}
  - Loads drive 0.
- Load extension:
  - Byte lane k = rdata[8k+7:8k], k = addr[1:0]; half = addr[1] ? rdata[31:16] : rdata[15:0].
  - lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word through.
- bus_ack outside REQ is ignored.
- M_loadData holds its last value until the next load completes.

## Timing
- Reset values: state IDLE; bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, M_loadData 0, M_loadValid 0.
- Minimum occupancy of a memory op in M is 3 cycles (IDLE, REQ with same-cycle ack, DONE). Each extra wait cycle in REQ adds 1.
- Cycle n: IDLE, M_stall=1. Cycle n+1: bus_req=1. Cycle n+k ack. Cycle n+k+1: DONE, M_stall=0, M_loadValid=1 for loads, pipeline advances at end of that cycle.
- Back-to-back memory ops: the second op enters in the cycle after DONE, in IDLE, and starts a new sequence. There are no idle gaps beyond the FSM's own states.
- Non-memory ops and misaligned ops pass with M_stall=0 in 1 cycle. M_excAd is valid in the same cycle.
- Reset in any state, including REQ mid-transaction, forces IDLE and all registered outputs to reset values at that edge. An abandoned request is dropped. The bus must tolerate a bus_req withdrawal.

## Test plan
- sw, addr 0x100, rt 0xDEADBEEF, ack on the first REQ cycle -> bus_we=1, addr 0x100, be 1111, wdata 0xDEADBEEF; M_stall high for 2 cycles, low in the 3rd.
- sb, addr 0x103, rt 0x000000A5 -> be 1000, wdata 0xA5A5A5A5. sh, addr 0x102, rt 0x1234 -> be 1100, wdata 0x12341234.
- lb, addr 0x101, rdata 0x00008000, ack delayed 3 cycles -> M_stall high 5 cycles, M_loadData 0xFFFFFF80, M_loadValid a single pulse. lbu on the same data -> 0x00000080.
- lh, addr 0x102, rdata 0x8001FFFF -> 0xFFFF8001. lw, addr 0x101 -> M_excAd=1, bus_req stays 0, M_stall=0.
- Reset asserted on the second REQ cycle of a lw -> next cycle bus_req=0, state IDLE, M_loadValid=0. A late bus_ack is ignored.
- Two consecutive loads, then a bubble (M_valid=0) with a memory opcode -> 3+3 stall-controlled cycles, then no request and M_stall=0.
